// File: rtl/pss_peak_tracker.sv
// pss_peak_tracker: multi-channel PSS peak detector with sliding-mean threshold and SSB-period tracking.
module pss_peak_tracker #(
  parameter int NUM_CH       = 3,
  parameter int IN_DW        = 32,
  parameter int WINDOW_LEN   = 8,
  parameter int THRESH_SHIFT = 3,
  parameter int MIN_LEVEL    = 0,
  parameter int SSB_INTERVAL = 38400,
  parameter int TRACK_TOL    = 100,
  parameter int MAX_MISS     = 3,
  parameter bit TRACK_EN     = 1'b1,
  localparam int CW = $clog2(NUM_CH),
  localparam int MW = $clog2(MAX_MISS + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [NUM_CH*IN_DW-1:0] s_axis_in_tdata,
  input  logic                    s_axis_in_tvalid,
  input  logic [1:0]              mode_i,
  input  logic [CW-1:0]           requested_N_id_2_i,
  output logic [CW-1:0]           N_id_2_o,
  output logic                    N_id_2_valid_o,
  output logic [IN_DW-1:0]        peak_score_o,
  output logic                    locked_o,
  output logic [MW-1:0]           miss_cnt_o,
  output logic                    correlator_en_o
);
  localparam int LW  = $clog2(WINDOW_LEN);
  localparam int SW  = IN_DW + LW;
  localparam int TW  = IN_DW + THRESH_SHIFT;
  localparam int SCW = $clog2(SSB_INTERVAL + TRACK_TOL + 1);
  typedef enum logic [1:0] {IDLE, SEARCH, TRACK, PAUSED} state_t;
  state_t state;
  logic [IN_DW-1:0] hist [NUM_CH][WINDOW_LEN];
  logic [SW-1:0] sum [NUM_CH];
  logic [LW:0] fill;
  logic [SCW-1:0] cnt, cur;
  logic [IN_DW-1:0] x, cand_x;
  logic [TW-1:0] thr;
  logic [CW-1:0] cand_id;
  logic cand_ok, full, pause, find, win, hit;
  assign pause = mode_i[1];
  assign find  = mode_i == 2'd1;
  assign full  = fill == (LW + 1)'(WINDOW_LEN);
  // cur is the position of the sample being presented, counted from the last hit
  assign cur   = cnt + 1'b1;
  assign win   = cur >= SCW'(SSB_INTERVAL - TRACK_TOL) && cur <= SCW'(SSB_INTERVAL + TRACK_TOL);
  assign hit   = cand_ok && cand_id == N_id_2_o && win;
  always_ff @(posedge clk_i) begin
    if (!reset_ni || pause) begin
      fill <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        for (int k = 0; k < WINDOW_LEN; k++) hist[c][k] <= '0;
      end
    end else if (s_axis_in_tvalid) begin
      fill <= full ? fill : fill + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= sum[c] + SW'(s_axis_in_tdata[c*IN_DW +: IN_DW]) - SW'(hist[c][WINDOW_LEN-1]);
        hist[c][0] <= s_axis_in_tdata[c*IN_DW +: IN_DW];
        for (int k = 1; k < WINDOW_LEN; k++) hist[c][k] <= hist[c][k-1];
      end
    end
  end
  // strictly-greater keeps the lowest index on ties
  always_comb begin
    cand_ok = 1'b0;
    cand_id = '0;
    cand_x  = '0;
    x       = '0;
    thr     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      x   = s_axis_in_tdata[c*IN_DW +: IN_DW];
      thr = TW'(sum[c] >> LW) << THRESH_SHIFT;
      if (s_axis_in_tvalid && full && x > IN_DW'(MIN_LEVEL) && TW'(x) >= thr &&
          (!find || requested_N_id_2_i == CW'(c)) && (!cand_ok || x > cand_x)) begin
        cand_ok = 1'b1;
        cand_id = CW'(c);
        cand_x  = x;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state           <= IDLE;
      N_id_2_o        <= '0;
      N_id_2_valid_o  <= 1'b0;
      peak_score_o    <= '0;
      locked_o        <= 1'b0;
      miss_cnt_o      <= '0;
      correlator_en_o <= 1'b0;
      cnt             <= '0;
    end else begin
      N_id_2_valid_o  <= 1'b0;
      correlator_en_o <= !pause;
      if (pause) begin
        state      <= PAUSED;
        locked_o   <= 1'b0;
        miss_cnt_o <= '0;
      end else begin
        case (state)
          IDLE, PAUSED: state <= SEARCH;
          SEARCH: if (cand_ok) begin
            N_id_2_valid_o <= 1'b1;
            N_id_2_o       <= cand_id;
            peak_score_o   <= cand_x;
            if (TRACK_EN) begin
              state      <= TRACK;
              locked_o   <= 1'b1;
              cnt        <= '0;
              miss_cnt_o <= '0;
            end
          end
          TRACK: if (find && requested_N_id_2_i != N_id_2_o) begin
            state      <= SEARCH;
            locked_o   <= 1'b0;
            miss_cnt_o <= '0;
          end else if (s_axis_in_tvalid) begin
            if (hit) begin
              N_id_2_valid_o <= 1'b1;
              peak_score_o   <= cand_x;
              cnt            <= '0;
              miss_cnt_o     <= '0;
            end else if (cur == SCW'(SSB_INTERVAL + TRACK_TOL)) begin
              if (miss_cnt_o == MW'(MAX_MISS - 1)) begin
                state      <= SEARCH;
                locked_o   <= 1'b0;
                miss_cnt_o <= '0;
              end else begin
                miss_cnt_o <= miss_cnt_o + 1'b1;
                cnt        <= SCW'(TRACK_TOL);
              end
            end else cnt <= cur;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pss_peak_tracker.sv
// tb_pss_peak_tracker: directed stimulus with a queue scoreboard checking every valid pulse.
module tb_pss_peak_tracker;
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic [95:0] tdata = '0;
  logic tvalid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] req = 2'd0;
  logic [1:0] id;
  logic valid;
  logic [31:0] score;
  logic locked;
  logic [1:0] miss;
  logic en;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [1:0] id; logic [31:0] score;} exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  pss_peak_tracker #(.SSB_INTERVAL(400), .TRACK_TOL(20)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
    .mode_i(mode), .requested_N_id_2_i(req), .N_id_2_o(id), .N_id_2_valid_o(valid),
    .peak_score_o(score), .locked_o(locked), .miss_cnt_o(miss), .correlator_en_o(en)
  );
  always @(negedge clk) if (valid === 1'b1) begin
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got id=%0d score=%0d, expected no pulse", id, score);
    end else begin
      e = q.pop_front();
      if (id !== e.id || score !== e.score) begin
        errors++;
        $display("FAIL pulse: got id=%0d score=%0d, expected id=%0d score=%0d", id, score, e.id, e.score);
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic v);
    tdata = {c, b, a};
    tvalid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic consts(input int n);
    for (int i = 0; i < n; i++) step(10, 10, 10, 1'b1);
  endtask
  task automatic push(input logic [1:0] i, input logic [31:0] s);
    exp_t t;
    t.id = i;
    t.score = s;
    q.push_back(t);
  endtask
  initial begin
    repeat (3) step(10, 10, 10, 1'b1);
    check("rst_valid", 32'(valid), 0);
    check("rst_id", 32'(id), 0);
    check("rst_score", score, 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_en", 32'(en), 0);
    reset_ni = 1'b1;
    consts(50);
    check("en_after_idle", 32'(en), 1);
    push(2'd1, 1000);
    step(10, 1000, 10, 1'b1);
    check("locked_first", 32'(locked), 1);
    consts(5);
    mode = 2'd2;
    step(10, 10, 10, 1'b1);
    check("pause_en", 32'(en), 0);
    check("pause_locked", 32'(locked), 0);
    step(10, 1000, 10, 1'b1);
    mode = 2'd0;
    consts(7);
    step(1000, 10, 10, 1'b1);
    check("resume_en", 32'(en), 1);
    consts(16);
    push(2'd0, 900);
    step(900, 10, 900, 1'b1);
    check("tie_locked", 32'(locked), 1);
    consts(200);
    repeat (7) step(10, 10, 10, 1'b0);
    consts(199);
    push(2'd0, 700);
    step(700, 10, 10, 1'b1);
    consts(379);
    push(2'd0, 800);
    step(800, 10, 10, 1'b1);
    consts(419);
    check("miss_before_close", 32'(miss), 0);
    consts(1);
    check("miss_at_close", 32'(miss), 1);
    consts(9);
    step(900, 10, 10, 1'b1);
    check("late_peak_miss", 32'(miss), 1);
    check("late_peak_locked", 32'(locked), 1);
    consts(389);
    check("miss_hold", 32'(miss), 1);
    consts(1);
    check("miss_two", 32'(miss), 2);
    consts(399);
    check("locked_before_loss", 32'(locked), 1);
    consts(1);
    check("locked_lost", 32'(locked), 0);
    check("miss_cleared", 32'(miss), 0);
    mode = 2'd1;
    req = 2'd2;
    consts(10);
    step(10, 1000, 10, 1'b1);
    consts(3);
    push(2'd2, 500);
    step(10, 10, 500, 1'b1);
    check("find_locked", 32'(locked), 1);
    req = 2'd0;
    step(10, 10, 10, 1'b0);
    check("find_change_unlock", 32'(locked), 0);
    mode = 2'd0;
    consts(10);
    push(2'd1, 600);
    step(10, 600, 10, 1'b1);
    check("relock", 32'(locked), 1);
    reset_ni = 1'b0;
    step(10, 10, 10, 1'b1);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_score", score, 0);
    reset_ni = 1'b1;
    consts(3);
    check("post_rst_en", 32'(en), 1);
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
